// File: rtl/icache_loader.sv
// icache_loader: streams 32-bit instruction words into a byte-wide,
// little-endian instruction memory, one byte per cycle from address 0.
// Stops on the 0xFFFFFFFF sentinel (which is itself written) or when full.
// Optional: define ICACHE_LOADER_CHECKSUM_EN to add a running word checksum.
module icache_loader #(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 60,
  parameter int WIDTH_ADD = 6,
  parameter int BYTE      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 mem_we,
  output logic [WIDTH_ADD-1:0] mem_addr,
  output logic [BYTE-1:0]      mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [WIDTH_ADD-1:0] word_count
`ifdef ICACHE_LOADER_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]     checksum
`endif
);

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, FINISH} state_t;

  // Highest base address at which a full word still fits.
  localparam logic [WIDTH_ADD+1:0] LAST_BASE = (WIDTH_ADD+2)'(SIZE - 4);

  state_t               state, state_next;
  logic [WIDTH-1:0]     word;
  logic [WIDTH_ADD-1:0] base;
  logic [1:0]           idx;
  logic [1:0]           idx_next;
  logic [WIDTH_ADD+1:0] base_next;
  logic                 accept;
  logic                 last_byte;
  logic                 sentinel;
  logic                 full;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state selection; the sentinel check outranks the full check
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCEPT;
      ACCEPT:  if (in_valid) state_next = WRITE;
      WRITE:   if (last_byte) state_next = (sentinel || full) ? FINISH : ACCEPT;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Combinational outputs and derived control terms
  always_comb begin
    in_ready  = (state == ACCEPT);
    busy      = (state == ACCEPT) || (state == WRITE);
    accept    = in_ready && in_valid;
    last_byte = (state == WRITE) && (idx == 2'd3);
    idx_next  = idx + 2'd1;
    base_next = {2'b00, base} + (WIDTH_ADD+2)'(4);
    sentinel  = (word == '1);
    full      = (base_next > LAST_BASE);
  end

  // Datapath: registered memory write port, word latch, status flags.
  // The memory port is loaded one cycle ahead so it lines up with WRITE:
  // the accept cycle presents byte 0 straight from in_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      word       <= '0;
      base       <= '0;
      idx        <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
`ifdef ICACHE_LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      if (state == IDLE && start) begin
        done       <= 1'b0;
        overflow   <= 1'b0;
        word_count <= '0;
        base       <= '0;
`ifdef ICACHE_LOADER_CHECKSUM_EN
        checksum   <= '0;
`endif
      end
      if (accept) begin
        word       <= in_data;
        idx        <= 2'd0;
        word_count <= word_count + 1'b1;
        mem_we     <= 1'b1;
        mem_addr   <= base;
        mem_wdata  <= in_data[BYTE-1:0];
`ifdef ICACHE_LOADER_CHECKSUM_EN
        checksum   <= checksum + in_data;
`endif
      end else if (state == WRITE) begin
        if (idx == 2'd3) begin
          mem_we <= 1'b0;
          base   <= base_next[WIDTH_ADD-1:0];
          if (!sentinel && full) overflow <= 1'b1;
        end else begin
          idx       <= idx_next;
          mem_we    <= 1'b1;
          mem_addr  <= base + WIDTH_ADD'(idx_next);
          mem_wdata <= word[BYTE*int'(idx_next) +: BYTE];
        end
      end
      if (state == FINISH) done <= 1'b1;
    end
  end

endmodule

// File: doc/icache_loader.md
Name: icache_loader

Overview:
- Write-side companion to the byte-addressed, little-endian instruction memory. The instruction memory has a 6-bit byte address and returns a 32-bit word assembled from mem[a+3..a].
- Accepts 32-bit instruction words over a valid/ready stream and writes them into the byte-wide memory, one byte per cycle, starting at byte address 0.
- Stops at the end-of-program sentinel 0xFFFFFFFF or when memory is full.
- Sits between the program source (testbench or boot stream) and the instruction memory write port.

Parameters:
- WIDTH, 32, instruction word width.
- SIZE, 60, memory size in bytes. Must be a multiple of 4.
- WIDTH_ADD, 6, byte address width.
- BYTE, 8, memory data width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  one-cycle pulse; begins a load at byte address 0.
- in_valid  input  1  in_data holds a valid word.
- in_ready  output  1  loader accepts a word this cycle.
- in_data  input  WIDTH  instruction word.
- mem_we  output  1  byte write enable.
- mem_addr  output  WIDTH_ADD  byte address.
- mem_wdata  output  BYTE  byte to write.
- busy  output  1  load in progress.
- done  output  1  load finished; sticky until next start or rst.
- overflow  output  1  memory filled without seeing the sentinel; sticky like done.
- word_count  output  WIDTH_ADD  words accepted in current/last load.

Behaviour:
- Reset (rst high at a clock edge):
  - State IDLE.
  - in_ready, mem_we, busy, done, overflow = 0.
  - mem_addr, mem_wdata, word_count = 0.
  - Reset mid-load aborts immediately: mem_we is 0 from the edge after rst, and no further bytes are written.
- States: IDLE, ACCEPT, WRITE, FINISH.
- IDLE:
  - start=1 → ACCEPT. Clears done, overflow, word_count; sets base address to 0; busy=1.
- ACCEPT:
  - in_ready=1 combinationally in this state only.
  - On in_valid&&in_ready: latch in_data, word_count+1, byte index 0, → WRITE.
  - in_valid=0 stalls in ACCEPT with mem_we=0.
- WRITE (4 cycles, byte index k = 0..3):
  - mem_we=1, mem_addr = base+k, mem_wdata = word[8k+7:8k]. This is little-endian, matching the read-side assembly.
  - in_ready=0.
  - After k=3, base is incremented by 4.
  - Latched word == 0xFFFFFFFF → FINISH. The sentinel itself is written.
  - Else if base+4 > SIZE (next word would not fit) → FINISH with overflow=1.
  - Else → ACCEPT.
- FINISH:
  - done=1, busy=0, mem_we=0. Next cycle → IDLE; done and overflow remain held.
- Latency: minimum 5 cycles per word (1 accept + 4 writes). First accept is possible 1 cycle after start.
- mem_we, mem_addr and mem_wdata are registered outputs.
- mem_addr never exceeds SIZE-1. With SIZE=60 the last word lands at 56..59.
- Sentinel as the 15th word at 56..59: done=1, overflow=0. The sentinel check takes priority over the full check.
- start while busy: ignored.
- start in IDLE while done=1: restarts the load and clears done/overflow.
- rst and start in the same cycle: rst wins.

Optional Feature:
- Macro ICACHE_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output checksum [WIDTH-1:0]: sum modulo 2^WIDTH of every accepted word, sentinel included.
  - Cleared on start and on rst; updated in the accept cycle.
  - Valid when done=1.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- rst, start, words 0xE0210001, 0xE8010000, 0xFFFFFFFF with in_valid held → bytes at 0..3 = 01,00,21,E0; 4..7 = 00,00,01,E8; 8..11 = FF×4; done=1, overflow=0, word_count=3; done rises 16 cycles after the start edge.
- 15 non-sentinel words 0x00000001..0x0000000F → last write at 56..59 = 0F,00,00,00; done=1, overflow=1, word_count=15; mem_addr never reaches 60.
- in_valid low for 3 cycles in ACCEPT between words → in_ready stays 1, mem_we=0 throughout the stall, write addresses stay contiguous.
- rst asserted during the WRITE of byte index 2 of word 2 (address 6) → mem_we=0 next cycle, all outputs 0, address 7 never written; a following start reloads from address 0.
- start pulsed while busy → no effect; start after done → done and overflow clear, word_count=0, loading resumes from address 0.
- ICACHE_LOADER_CHECKSUM_EN defined, words 0x00000005, 0x00000007, 0xFFFFFFFF → checksum=0x0000000B at done.
